// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type and default geometry for the register file
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: sequenced clear engine that sweeps every register to zero, one per cycle
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              idle,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'((2 ** ADDR_W) - 1);
  clr_state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  // state and sweep index registers; index is held at zero outside the sweep so every sweep starts at 0
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= (state == SWEEP) ? idx + 1'b1 : '0;
    end
  // next state: request starts a sweep, last index ends it, done lasts a single cycle
  always_comb
    state_nx = (state == IDLE)  ? (clear_req ? SWEEP : IDLE) :
               (state == SWEEP) ? ((idx == LAST) ? DONE : SWEEP) : IDLE;
  // Moore outputs decoded from the current state
  always_comb begin
    clear_busy = (state == SWEEP);
    clear_done = (state == DONE);
    idle       = (state == IDLE);
    clr_en     = (state == SWEEP);
    clr_idx    = idx;
  end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R/1W register file with clear engine; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
module regfile_param import regfile_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              idle, clr_en, wr_ok;
  logic [ADDR_W-1:0] clr_idx;
  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .idle       (idle),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx)
  );
  // a write is accepted only while the clear engine is idle and never to a hardwired-zero register 0
  always_comb wr_ok = RegWrite && idle && !(ZERO_REG0 != 0 && WriteReg == '0);
  // storage: sweep clear and writes are mutually exclusive because writes need the engine idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  // combinational read ports with optional forwarding of the accepted write
  always_comb begin
    ReadData1 = (ZERO_REG0 != 0 && ReadReg1 == '0) ? '0 : regs[ReadReg1];
    ReadData2 = (ZERO_REG0 != 0 && ReadReg2 == '0) ? '0 : regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && WriteReg == ReadReg1) ReadData1 = WriteData;
    if (wr_ok && WriteReg == ReadReg2) ReadData2 = WriteData;
`endif
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and random checks of regfile_param (plain and zero-reg0 builds) against an array model
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        reset, RegWrite, clear_req;
  logic [1:0]  WriteReg, ReadReg1, ReadReg2;
  logic [31:0] WriteData;
  logic [31:0] rd1a, rd2a, rd1b, rd2b;
  logic        busya, donea, busyb, doneb;
  int          checks = 0, errors = 0;
  int          pos = -1;
  logic [31:0] m0 [4];
  logic [31:0] m1 [4];

  always #10 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_REG0(0)) dut_a (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1a), .ReadData2(rd2a),
    .clear_req(clear_req), .clear_busy(busya), .clear_done(donea)
  );
  regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_REG0(1)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1b), .ReadData2(rd2b),
    .clear_req(clear_req), .clear_busy(busyb), .clear_done(doneb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit z, input logic [1:0] a);
    if (z && a == 2'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (pos < 0 && RegWrite && WriteReg == a) return WriteData;
`endif
    return z ? m1[a] : m0[a];
  endfunction

  task automatic check_all();
    chk("rd1_plain", rd1a, exp_rd(1'b0, ReadReg1));
    chk("rd2_plain", rd2a, exp_rd(1'b0, ReadReg2));
    chk("rd1_zero0", rd1b, exp_rd(1'b1, ReadReg1));
    chk("rd2_zero0", rd2b, exp_rd(1'b1, ReadReg2));
    chk("busy_plain", 32'(busya), 32'(pos >= 0 && pos < 4));
    chk("done_plain", 32'(donea), 32'(pos == 4));
    chk("busy_zero0", 32'(busyb), 32'(pos >= 0 && pos < 4));
    chk("done_zero0", 32'(doneb), 32'(pos == 4));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m0[i] = 32'd0;
      m1[i] = 32'd0;
    end
    pos = -1;
  endtask

  // pos = -1 idle, 0..3 register being swept this cycle, 4 done pulse
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (pos < 0) begin
      if (RegWrite) begin
        m0[WriteReg] = WriteData;
        if (WriteReg != 2'd0) m1[WriteReg] = WriteData;
      end
      if (clear_req) pos = 0;
    end else if (pos < 4) begin
      m0[pos] = 32'd0;
      m1[pos] = 32'd0;
      pos++;
    end else begin
      pos = -1;
    end
  endtask

  task automatic cyc(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                     input logic [1:0] a1, input logic [1:0] a2, input logic cr);
    RegWrite = we; WriteReg = wa; WriteData = wd;
    ReadReg1 = a1; ReadReg2 = a2; clear_req = cr;
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; RegWrite = 1'b0; clear_req = 1'b0;
    WriteReg = 2'd0; WriteData = 32'd0; ReadReg1 = 2'd0; ReadReg2 = 2'd0;
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ReadReg1 = 2'(i); ReadReg2 = 2'(3 - i);
      #1 check_all();
    end
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 2'd2, 32'hDEADBEEF, 2'd2, 2'd2, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd2, 2'd2, 1'b0);
    cyc(1'b1, 2'd3, 32'h12345678, 2'd3, 2'd1, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd3, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 32'(i + 1), 2'(i), 2'(3 - i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 32'd0, 2'(i), 2'(3 - i), 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd1, 2'd2, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, 32'hFF, 2'd1, 2'(i), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 32'd0, 2'(i), 2'(3 - i), 1'b0);
    cyc(1'b1, 2'd0, 32'hAAAA5555, 2'd0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd0, 2'd0, 1'b0);
    cyc(1'b1, 2'd2, 32'hCAFEF00D, 2'd2, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 32'd0, 2'(i), 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 32'h5A5A0000 + 32'(i), 2'(i), 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd0, 2'd3, 1'b1);
    cyc(1'b0, 2'd0, 32'd0, 2'd0, 2'd3, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 2'd2, 2'd3, 1'b0);
    reset = 1'b1;
    #1 model_reset();
    check_all();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 32'd0, 2'(i), 2'(3 - i), 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 32'd0, 2'(i), 2'(3 - i), 1'b0);
    for (int n = 0; n < 400; n++)
      cyc(1'($urandom), 2'($urandom), $urandom, 2'($urandom), 2'($urandom),
          1'($urandom_range(0, 15) == 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
